hazard_unit_sb: RTL and testbench

Parametrised hazard unit for the five-stage RISC-V pipeline with long-latency (multi-cycle) functional-unit support. Combines combinational EX-stage forwarding, load-use and branch hazard control with a per-register scoreboard and an outstanding-operation limiter for out-of-band units such as mul/div. It sits beside the datapath, reads register indices from the D/E/M/W pipeline registers, and drives the stall/flush/forward controls. A saturating stall-cycle counter supports performance measurement.

---
 rtl/hazard_unit_sb_if.sv | 48 ++++
 rtl/hazard_unit_sb.sv | 135 +++++++++++++
 tb/tb_hazard_unit_sb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_sb_if.sv
// Hazard-unit bundle: pipeline register indices and enables in, stall/flush/forward controls out.
// The datapath holds the master side; the hazard unit holds the slave side.
interface hazard_unit_sb_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned OW = 3
);
    logic [AW-1:0] Rs1D;
    logic [AW-1:0] Rs2D;
    logic [AW-1:0] RdD;
    logic          RegWriteD;
    logic          LongD;
    logic [AW-1:0] Rs1E;
    logic [AW-1:0] Rs2E;
    logic [AW-1:0] RdE;
    logic          ResultSrcb0E;
    logic          PCSrcE;
    logic          LongIssueE;
    logic [AW-1:0] RdM;
    logic [AW-1:0] RdW;
    logic          RegWriteM;
    logic          RegWriteW;
    logic          LongDoneW;
    logic [AW-1:0] LongRdW;
    logic [1:0]    ForwardAE;
    logic [1:0]    ForwardBE;
    logic          StallF;
    logic          StallD;
    logic          FlushD;
    logic          FlushE;
    logic [OW-1:0] Outstanding;
    logic [31:0]   StallCycles;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, LongD,
        output Rs1E, Rs2E, RdE, ResultSrcb0E, PCSrcE, LongIssueE,
        output RdM, RdW, RegWriteM, RegWriteW, LongDoneW, LongRdW,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  Outstanding, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, LongD,
        input  Rs1E, Rs2E, RdE, ResultSrcb0E, PCSrcE, LongIssueE,
        input  RdM, RdW, RegWriteM, RegWriteW, LongDoneW, LongRdW,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output Outstanding, StallCycles
    );
endinterface

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the five-stage pipeline: EX forwarding, load-use and branch control,
// plus a per-register scoreboard and outstanding-op limiter for long-latency units.
module hazard_unit_sb #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned OW      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_unit_sb_if.slave  hz_io
);
    localparam int unsigned NIDX = 1 << AW;

    logic [NREG-1:0] pending_q, pending_d;
    logic [NIDX-1:0] pend_full;
    logic [NIDX-1:0] eff;
    logic [OW-1:0]   out_q, out_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [OW:0]     out_proj;
    logic            done_acc;
    logic            lw_stall;
    logic            sb_stall;
    logic            lim_stall;
    logic            haz_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] rs,
        input logic [AW-1:0] rd_m,
        input logic          wr_m,
        input logic [AW-1:0] rd_w,
        input logic          wr_w
    );
        if (rs == '0) begin
            return 2'b00;
        end
        if (wr_m && (rd_m == rs)) begin
            return 2'b10;
        end
        if (wr_w && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign hz_io.ForwardAE = fwd_sel(hz_io.Rs1E, hz_io.RdM, hz_io.RegWriteM,
                                     hz_io.RdW, hz_io.RegWriteW);
    assign hz_io.ForwardBE = fwd_sel(hz_io.Rs2E, hz_io.RdM, hz_io.RegWriteM,
                                     hz_io.RdW, hz_io.RegWriteW);

    assign lw_stall = hz_io.ResultSrcb0E && (hz_io.RdE != '0) &&
                      ((hz_io.Rs1D == hz_io.RdE) || (hz_io.Rs2D == hz_io.RdE));

    // Padded to the full index space so any AW-bit index is in range.
    always_comb begin
        pend_full = '0;
        pend_full[NREG-1:0] = pending_q;
        pend_full[0] = 1'b0;
    end

    // Completions are visible to D this cycle (write-first RF); issues are bypassed in.
    always_comb begin
        eff = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            eff[r] = (pend_full[r] && !(hz_io.LongDoneW && (hz_io.LongRdW == AW'(r)))) ||
                     (hz_io.LongIssueE && (hz_io.RdE == AW'(r)));
        end
    end

    assign sb_stall = eff[hz_io.Rs1D] || eff[hz_io.Rs2D] ||
                      (hz_io.RegWriteD && eff[hz_io.RdD]);

    // Completion in the same cycle earns no credit toward a new long op.
    assign out_proj  = {1'b0, out_q} + (OW + 1)'(hz_io.LongIssueE);
    assign lim_stall = hz_io.LongD && (32'(out_proj) >= MAX_OUT);

    assign haz_stall = lw_stall || sb_stall || lim_stall;

    assign hz_io.StallF      = haz_stall;
    assign hz_io.StallD      = haz_stall;
    assign hz_io.FlushD      = hz_io.PCSrcE;
    assign hz_io.FlushE      = haz_stall || hz_io.PCSrcE;
    assign hz_io.Outstanding = out_q;
    assign hz_io.StallCycles = stall_cnt_q;

    assign done_acc = hz_io.LongDoneW && pend_full[hz_io.LongRdW];

    // Clear before set so a younger issue to the same register wins.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (done_acc && (hz_io.LongRdW == AW'(r))) begin
                pending_d[r] = 1'b0;
            end
            if (hz_io.LongIssueE && (hz_io.RdE == AW'(r))) begin
                pending_d[r] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        out_d = out_q;
        if (hz_io.LongIssueE && !done_acc && (32'(out_q) < MAX_OUT)) begin
            out_d = out_q + OW'(1);
        end else if (done_acc && !hz_io.LongIssueE && (out_q != '0)) begin
            out_d = out_q - OW'(1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (haz_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            out_q       <= out_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    a_out_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(out_q) <= MAX_OUT);
    a_x0_clear: assert property (@(posedge clk) disable iff (!rst_n)
        pending_q[0] == 1'b0);

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench for hazard_unit_sb: table of combinational vectors plus
// hand-written scoreboard, limiter and reset sequences.
module tb_hazard_unit_sb;
    typedef struct packed {
        logic [4:0] rs1d, rs2d, rdd;
        logic       regwd, longd;
        logic [4:0] rs1e, rs2e, rde;
        logic       lde, pcsrc, issue;
        logic [4:0] rdm, rdw;
        logic       regwm, regww, done;
        logic [4:0] donerd;
    } in_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       stall, fd, fe;
    } exp_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  ex;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   sc_m  = 0;
    exp_t  exp_q[$];
    string nm_q[$];
    vec_t  tbl[$];

    always #5 clk = ~clk;

    hazard_unit_sb_if #(.AW(5), .OW(3)) hz ();

    hazard_unit_sb #(.NREG(32), .AW(5), .MAX_OUT(4), .OW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_io (hz)
    );

    function automatic in_t idle();
        in_t t;
        t = '0;
        return t;
    endfunction

    function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                                input logic st, input logic fd, input logic fe);
        exp_t e;
        e.fa = fa; e.fb = fb; e.stall = st; e.fd = fd; e.fe = fe;
        return e;
    endfunction

    task automatic drive(input in_t i);
        hz.Rs1D = i.rs1d; hz.Rs2D = i.rs2d; hz.RdD = i.rdd;
        hz.RegWriteD = i.regwd; hz.LongD = i.longd;
        hz.Rs1E = i.rs1e; hz.Rs2E = i.rs2e; hz.RdE = i.rde;
        hz.ResultSrcb0E = i.lde; hz.PCSrcE = i.pcsrc; hz.LongIssueE = i.issue;
        hz.RdM = i.rdm; hz.RdW = i.rdw; hz.RegWriteM = i.regwm; hz.RegWriteW = i.regww;
        hz.LongDoneW = i.done; hz.LongRdW = i.donerd;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // One cycle: drive at negedge, queue expectation, compare once settled.
    task automatic step(input string name, input in_t i, input exp_t e);
        exp_t  x;
        string n;
        @(negedge clk);
        drive(i);
        exp_q.push_back(e);
        nm_q.push_back(name);
        #2;
        x = exp_q.pop_front();
        n = nm_q.pop_front();
        chk({n, ".ForwardAE"}, 32'(hz.ForwardAE), 32'(x.fa));
        chk({n, ".ForwardBE"}, 32'(hz.ForwardBE), 32'(x.fb));
        chk({n, ".StallF"},    32'(hz.StallF),    32'(x.stall));
        chk({n, ".StallD"},    32'(hz.StallD),    32'(x.stall));
        chk({n, ".FlushD"},    32'(hz.FlushD),    32'(x.fd));
        chk({n, ".FlushE"},    32'(hz.FlushE),    32'(x.fe));
        @(posedge clk);
        if (x.stall) sc_m++;
    endtask

    task automatic chk_reg(input string name, input int want_out);
        #1;
        chk({name, ".Outstanding"}, 32'(hz.Outstanding), 32'(want_out));
        chk({name, ".StallCycles"}, hz.StallCycles, 32'(sc_m));
    endtask

    task automatic add(input string n, input in_t i, input exp_t e);
        vec_t v;
        v.name = n; v.in = i; v.ex = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        in_t t;
        drive(idle());
        #1 rst_n = 1'b0;
        #1;
        chk("reset.Outstanding", 32'(hz.Outstanding), 32'd0);
        chk("reset.StallCycles", hz.StallCycles, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step("idle", idle(), mk(2'b00, 2'b00, 0, 0, 0));
        chk_reg("idle", 0);

        // Load-use: exactly one stall cycle, counter 0 -> 1.
        t = idle(); t.lde = 1; t.rde = 7; t.rs2d = 7;
        step("lduse", t, mk(2'b00, 2'b00, 1, 0, 1));
        chk_reg("lduse", 0);
        step("lduse_after", idle(), mk(2'b00, 2'b00, 0, 0, 0));
        chk_reg("lduse_after", 0);

        t = idle(); t.rs1e = 5; t.rdm = 5; t.regwm = 1; t.rdw = 5; t.regww = 1;
        add("fwdA_M_over_W", t, mk(2'b10, 2'b00, 0, 0, 0));
        t = idle(); t.rs2e = 6; t.rdw = 6; t.regww = 1;
        add("fwdB_W", t, mk(2'b00, 2'b01, 0, 0, 0));
        t = idle(); t.rs1e = 0; t.rdm = 0; t.regwm = 1;
        add("fwd_x0", t, mk(2'b00, 2'b00, 0, 0, 0));
        t = idle(); t.rs1e = 8; t.rdm = 8; t.regwm = 0; t.rdw = 8; t.regww = 1;
        add("fwdA_M_nowrite", t, mk(2'b01, 2'b00, 0, 0, 0));
        t = idle(); t.rs1e = 3; t.rs2e = 4; t.rdm = 3; t.regwm = 1; t.rdw = 4; t.regww = 1;
        add("fwd_both", t, mk(2'b10, 2'b01, 0, 0, 0));
        t = idle(); t.rs2e = 9; t.rdm = 10; t.regwm = 1; t.rdw = 11; t.regww = 1;
        add("fwd_nomatch", t, mk(2'b00, 2'b00, 0, 0, 0));
        t = idle(); t.lde = 1; t.rde = 7; t.rs1d = 7;
        add("lduse_rs1", t, mk(2'b00, 2'b00, 1, 0, 1));
        t = idle(); t.lde = 1; t.rde = 0; t.rs1d = 0;
        add("load_x0", t, mk(2'b00, 2'b00, 0, 0, 0));
        t = idle(); t.lde = 1; t.rde = 7; t.rs1d = 8; t.rs2d = 9;
        add("load_nomatch", t, mk(2'b00, 2'b00, 0, 0, 0));
        t = idle(); t.lde = 0; t.rde = 7; t.rs1d = 7;
        add("alu_no_lduse", t, mk(2'b00, 2'b00, 0, 0, 0));
        t = idle(); t.pcsrc = 1;
        add("branch", t, mk(2'b00, 2'b00, 0, 1, 1));
        t = idle(); t.pcsrc = 1; t.lde = 1; t.rde = 7; t.rs1d = 7;
        add("branch_lduse", t, mk(2'b00, 2'b00, 1, 1, 1));
        t = idle(); t.longd = 1;
        add("longd_free", t, mk(2'b00, 2'b00, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].name, tbl[k].in, tbl[k].ex);
        end
        chk_reg("table", 0);

        // Long op to x9: bypass, RAW, WAW, released in the completion cycle.
        t = idle(); t.issue = 1; t.rde = 9; t.rs1d = 9;
        step("x9_issue", t, mk(2'b00, 2'b00, 1, 0, 1));
        chk_reg("x9_issue", 1);
        t = idle(); t.rs1d = 9;
        step("x9_raw", t, mk(2'b00, 2'b00, 1, 0, 1));
        t = idle(); t.regwd = 1; t.rdd = 9;
        step("x9_waw", t, mk(2'b00, 2'b00, 1, 0, 1));
        t = idle(); t.rdd = 9;
        step("x9_rd_nowrite", t, mk(2'b00, 2'b00, 0, 0, 0));
        t = idle(); t.rs1d = 9; t.done = 1; t.donerd = 9;
        step("x9_done", t, mk(2'b00, 2'b00, 0, 0, 0));
        chk_reg("x9_done", 0);
        t = idle(); t.rs1d = 9;
        step("x9_after", t, mk(2'b00, 2'b00, 0, 0, 0));

        t = idle(); t.done = 1; t.donerd = 20;
        step("done_nonpend0", t, mk(2'b00, 2'b00, 0, 0, 0));
        chk_reg("done_nonpend0", 0);

        // Limiter: four ops to x1..x4.
        for (int r = 1; r <= 3; r++) begin
            t = idle(); t.issue = 1; t.rde = 5'(r);
            step("lim_issue", t, mk(2'b00, 2'b00, 0, 0, 0));
        end
        chk_reg("lim_issue3", 3);
        t = idle(); t.issue = 1; t.rde = 4; t.longd = 1;
        step("lim_issue4", t, mk(2'b00, 2'b00, 1, 0, 1));
        chk_reg("lim_issue4", 4);
        t = idle(); t.longd = 1;
        step("lim_hold", t, mk(2'b00, 2'b00, 1, 0, 1));
        chk_reg("lim_hold", 4);
        t = idle(); t.longd = 1; t.done = 1; t.donerd = 20;
        step("lim_spurious", t, mk(2'b00, 2'b00, 1, 0, 1));
        chk_reg("lim_spurious", 4);
        t = idle(); t.longd = 1; t.done = 1; t.donerd = 1;
        step("lim_nocredit", t, mk(2'b00, 2'b00, 1, 0, 1));
        chk_reg("lim_nocredit", 3);
        t = idle(); t.longd = 1;
        step("lim_release", t, mk(2'b00, 2'b00, 0, 0, 0));
        t = idle(); t.rs1d = 1;
        step("x1_cleared", t, mk(2'b00, 2'b00, 0, 0, 0));

        // Same-cycle set and clear of x3: set wins, count unchanged.
        t = idle(); t.issue = 1; t.rde = 3; t.done = 1; t.donerd = 3; t.rs1d = 3;
        step("x3_setclr", t, mk(2'b00, 2'b00, 1, 0, 1));
        chk_reg("x3_setclr", 3);
        t = idle(); t.rs1d = 3;
        step("x3_still", t, mk(2'b00, 2'b00, 1, 0, 1));
        t = idle(); t.rs2d = 2;
        step("x2_pend", t, mk(2'b00, 2'b00, 1, 0, 1));
        for (int r = 2; r <= 4; r++) begin
            t = idle(); t.done = 1; t.donerd = 5'(r);
            step("drain", t, mk(2'b00, 2'b00, 0, 0, 0));
        end
        chk_reg("drained", 0);
        t = idle(); t.rs1d = 3;
        step("x3_free", t, mk(2'b00, 2'b00, 0, 0, 0));

        // Asynchronous reset with an op in flight.
        t = idle(); t.issue = 1; t.rde = 12; t.rs1d = 12;
        step("x12_issue", t, mk(2'b00, 2'b00, 1, 0, 1));
        t = idle(); t.rs1d = 12;
        step("x12_raw", t, mk(2'b00, 2'b00, 1, 0, 1));
        chk_reg("x12_raw", 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sc_m = 0;
        chk("midrst.StallD", 32'(hz.StallD), 32'd0);
        chk("midrst.Outstanding", 32'(hz.Outstanding), 32'd0);
        chk("midrst.StallCycles", hz.StallCycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        t = idle(); t.rs1d = 12;
        step("x12_after_rst", t, mk(2'b00, 2'b00, 0, 0, 0));
        chk_reg("x12_after_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
